// File: rtl/input_video_timing.sv
// Recovers the active 720x576 picture window from the VP415 hsync/vsync pair and
// drives the framebuffer write-side enable and frame-restart pulse.
`timescale 1ns/1ps
module input_video_timing #(
  parameter int H_ACTIVE_START = 132,
  parameter int H_ACTIVE       = 720,
  parameter int HALF_LINE      = 432,
  parameter int V_ACTIVE_START = 23,
  parameter int V_ACTIVE       = 288,
  parameter int H_TIMEOUT      = 1000,
  parameter int LOCK_FIELDS    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] clkPhase,
  input  logic       hsync_n,
  input  logic       vsync_n,
  output logic       display_en_in,
  output logic       frame_start_flag_in,
  output logic       field_odd,
  output logic [9:0] line_count,
  output logic       locked
);

  localparam int CNT_W = $clog2(LOCK_FIELDS + 1);
  localparam logic [CNT_W-1:0] LOCK_TARGET = CNT_W'(LOCK_FIELDS);
  localparam logic [9:0] CNT_MAX   = 10'd1023;
  localparam logic [9:0] HALF_C    = 10'(HALF_LINE);
  localparam logic [9:0] TIMEOUT_C = 10'(H_TIMEOUT);
  localparam logic [9:0] H_BEG_C   = 10'(H_ACTIVE_START);
  localparam logic [9:0] H_END_C   = 10'(H_ACTIVE_START + H_ACTIVE);
  localparam logic [9:0] V_BEG_C   = 10'(V_ACTIVE_START);
  localparam logic [9:0] V_END_C   = 10'(V_ACTIVE_START + V_ACTIVE);

  typedef enum logic [1:0] {HUNT, QUAL, LOCKED} lock_state_t;

  lock_state_t state, state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt, cnt_inc;

  logic hs_p0, hs_p1, hs_p2;
  logic vs_p0, vs_p1, vs_p2;
  logic h_fall, v_fall, tick;
  logic [9:0] h_count;
  logic new_odd, field_good, timeout;
  logic h_win, v_win;
  logic fs_pending;

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous value for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_p0 <= 1'b1;
      hs_p1 <= 1'b1;
      hs_p2 <= 1'b1;
      vs_p0 <= 1'b1;
      vs_p1 <= 1'b1;
      vs_p2 <= 1'b1;
    end else begin
      hs_p0 <= hsync_n;
      hs_p1 <= hs_p0;
      hs_p2 <= hs_p1;
      vs_p0 <= vsync_n;
      vs_p1 <= vs_p0;
      vs_p2 <= vs_p1;
    end
  end

  assign h_fall = hs_p2 & ~hs_p1;
  assign v_fall = vs_p2 & ~vs_p1;
  assign tick   = (clkPhase == 3'd0);

  assign new_odd    = (h_count < HALF_C);
  assign field_good = ((line_count == 10'd312) || (line_count == 10'd313)) &&
                      (new_odd != field_odd);
  assign timeout    = (h_count >= TIMEOUT_C);

  // Stage p3: position counters and field parity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count    <= '0;
      line_count <= '0;
      field_odd  <= 1'b0;
    end else begin
      if (h_fall)
        h_count <= '0;
      else if (tick && (h_count != CNT_MAX))
        h_count <= h_count + 10'd1;

      if (v_fall) begin
        line_count <= '0;
        field_odd  <= new_odd;
      end else if (h_fall && (line_count != CNT_MAX)) begin
        line_count <= line_count + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HUNT;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  assign cnt_inc = lock_cnt + 1'b1;

  // Lock count is always zero in HUNT, so one increment rule serves HUNT and QUAL.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    if (timeout) begin
      state_nxt    = HUNT;
      lock_cnt_nxt = '0;
    end else if (v_fall) begin
      if (!field_good) begin
        state_nxt    = HUNT;
        lock_cnt_nxt = '0;
      end else if (state != LOCKED) begin
        lock_cnt_nxt = cnt_inc;
        state_nxt    = (cnt_inc >= LOCK_TARGET) ? LOCKED : QUAL;
      end
    end
  end

  assign locked = (state == LOCKED);

  assign h_win = (h_count >= H_BEG_C) && (h_count < H_END_C);
  assign v_win = (line_count >= V_BEG_C) && (line_count < V_END_C);

  // Stage p4: write-side controls. The pulse is registered on phase 0 so it is
  // high during the phase 1 cycle; display only moves on phase 5 so it stays
  // constant across every pixel's six SRAM slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_pending          <= 1'b0;
      frame_start_flag_in <= 1'b0;
      display_en_in       <= 1'b0;
    end else begin
      frame_start_flag_in <= 1'b0;
      if (state_nxt != LOCKED) begin
        fs_pending <= 1'b0;
      end else if (v_fall && new_odd) begin
        fs_pending <= 1'b1;
      end else if (fs_pending && tick && !display_en_in) begin
        fs_pending          <= 1'b0;
        frame_start_flag_in <= 1'b1;
      end

      if (clkPhase == 3'd5)
        display_en_in <= locked && v_win && h_win;
    end
  end

endmodule
